// File: rtl/write_unit.sv
// write_unit: FIFO write-side pointer, storage write port and full/level/almost-full status.
// mem_we same cycle as wr_en; wr_ptr/wr_ack 1 cycle later; writes while full are dropped (sticky overflow with WR_OVERFLOW_FLAG_EN).
module write_unit #(
   parameter int S         = 8,
   parameter int W         = 8,
   parameter int Depth     = 90,
   parameter int AF_THRESH = 80
) (
   input  logic         wr_clk,
   input  logic         wr_rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic [S-1:0] rd_ptr,
   output logic [S-1:0] wr_ptr,
   output logic         mem_we,
   output logic [S-2:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   output logic         fifo_full,
   output logic         almost_full,
   output logic [S-1:0] fill_level,
   output logic         wr_ack
`ifdef WR_OVERFLOW_FLAG_EN
   ,
   output logic         overflow
`endif
);

   localparam logic [S-2:0] LAST_IDX = (S-1)'(Depth - 1);
   localparam logic [S-1:0] DEPTH_S  = S'(Depth);
   localparam logic [S-1:0] AF_S     = S'(AF_THRESH);

   logic [S-1:0] wr_ptr_q, wr_ptr_d;
   logic         wr_ack_q, wr_ack_d;
   logic [S-2:0] wr_idx, rd_idx;
   logic         lap_diff;
   logic         acc;

   assign wr_idx   = wr_ptr_q[S-2:0];
   assign rd_idx   = rd_ptr[S-2:0];
   assign lap_diff = wr_ptr_q[S-1] ^ rd_ptr[S-1];

   always_comb begin
      fifo_full = lap_diff && (wr_idx == rd_idx);
      acc       = wr_en && !fifo_full;
      // Different laps means the writer has wrapped past the end of storage.
      if (lap_diff) begin
         fill_level = DEPTH_S - {1'b0, rd_idx} + {1'b0, wr_idx};
      end else begin
         fill_level = {1'b0, wr_idx} - {1'b0, rd_idx};
      end
      almost_full = (fill_level >= AF_S);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (acc) begin
         if (wr_idx < LAST_IDX) begin
            wr_ptr_d = {wr_ptr_q[S-1], wr_idx + 1'b1};
         end else if (wr_idx == LAST_IDX) begin
            wr_ptr_d = {~wr_ptr_q[S-1], {(S-1){1'b0}}};
         end
      end
      wr_ack_d = acc;
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wr_ptr_q <= '0;
         wr_ack_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         wr_ack_q <= wr_ack_d;
      end
   end

`ifdef WR_OVERFLOW_FLAG_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q | (wr_en & fifo_full);
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

   assign wr_ptr    = wr_ptr_q;
   assign wr_ack    = wr_ack_q;
   assign mem_we    = acc;
   assign mem_addr  = wr_idx;
   assign mem_wdata = wr_data;

endmodule

// File: tb/tb_write_unit.sv
// Directed self-checking bench for write_unit; rd_ptr is driven directly to stand in for the read stage.
module tb_write_unit;

   logic       wr_clk = 1'b0;
   logic       wr_rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] rd_ptr;
   logic [7:0] wr_ptr;
   logic       mem_we;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       fifo_full;
   logic       almost_full;
   logic [7:0] fill_level;
   logic       wr_ack;
`ifdef WR_OVERFLOW_FLAG_EN
   logic       overflow;
`endif

   int check_cnt = 0;
   int pass_cnt  = 0;

   always #5 wr_clk = ~wr_clk;

   write_unit #(.S(8), .W(8), .Depth(90), .AF_THRESH(80)) dut (
      .wr_clk      (wr_clk),
      .wr_rst      (wr_rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_ptr      (rd_ptr),
      .wr_ptr      (wr_ptr),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .fifo_full   (fifo_full),
      .almost_full (almost_full),
      .fill_level  (fill_level),
      .wr_ack      (wr_ack)
`ifdef WR_OVERFLOW_FLAG_EN
      ,
      .overflow    (overflow)
`endif
   );

   function automatic logic [7:0] nxt(input logic [7:0] p);
      if (p[6:0] == 7'd89) return {~p[7], 7'd0};
      return {p[7], p[6:0] + 7'd1};
   endfunction

   task automatic apply_reset();
      wr_rst  = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      rd_ptr  = 8'h00;
      @(negedge wr_clk);
      wr_rst = 1'b0;
   endtask

   task automatic do_writes(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         @(negedge wr_clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      wr_rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_ptr = 8'h00;
      #1;
      check_cnt++; if (wr_ptr !== 8'h00) $display("FAIL por_wr_ptr got %h want 00", wr_ptr); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b0) $display("FAIL por_full got %b want 0", fifo_full); else pass_cnt++;
      check_cnt++; if (mem_we !== 1'b0) $display("FAIL por_mem_we got %b want 0", mem_we); else pass_cnt++;
      @(negedge wr_clk);
      wr_rst = 1'b0;
      do_writes(3);
      check_cnt++; if (wr_ptr !== 8'h03) $display("FAIL pre_rst_wr_ptr got %h want 03", wr_ptr); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b1) $display("FAIL pre_rst_ack got %b want 1", wr_ack); else pass_cnt++;
      #2 wr_rst = 1'b1;
      #1;
      check_cnt++; if (wr_ptr !== 8'h00) $display("FAIL rst_wr_ptr got %h want 00", wr_ptr); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b0) $display("FAIL rst_full got %b want 0", fifo_full); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd0) $display("FAIL rst_fill got %0d want 0", fill_level); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b0) $display("FAIL rst_ack got %b want 0", wr_ack); else pass_cnt++;
      check_cnt++; if (almost_full !== 1'b0) $display("FAIL rst_af got %b want 0", almost_full); else pass_cnt++;
`ifdef WR_OVERFLOW_FLAG_EN
      check_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else pass_cnt++;
`endif
      @(negedge wr_clk);
      wr_rst = 1'b0;
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < 90; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i) ^ 8'h5A;
         #1;
         check_cnt++; if (mem_we !== 1'b1) $display("FAIL fill_mem_we[%0d] got %b want 1", i, mem_we); else pass_cnt++;
         check_cnt++; if (mem_addr !== 7'(i)) $display("FAIL fill_addr[%0d] got %0d want %0d", i, mem_addr, i); else pass_cnt++;
         check_cnt++; if (mem_wdata !== (8'(i) ^ 8'h5A)) $display("FAIL fill_wdata[%0d] got %h want %h", i, mem_wdata, 8'(i) ^ 8'h5A); else pass_cnt++;
         @(negedge wr_clk);
         check_cnt++; if (fill_level !== 8'(i + 1)) $display("FAIL fill_level[%0d] got %0d want %0d", i, fill_level, i + 1); else pass_cnt++;
         check_cnt++; if (almost_full !== (i + 1 >= 80)) $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 80)); else pass_cnt++;
      end
      wr_en = 1'b0;
      check_cnt++; if (wr_ptr !== 8'h80) $display("FAIL fill_wr_ptr got %h want 80", wr_ptr); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b1) $display("FAIL fill_full got %b want 1", fifo_full); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd90) $display("FAIL fill_final got %0d want 90", fill_level); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b1) $display("FAIL fill_ack got %b want 1", wr_ack); else pass_cnt++;
      @(negedge wr_clk);
      check_cnt++; if (wr_ack !== 1'b0) $display("FAIL fill_ack_idle got %b want 0", wr_ack); else pass_cnt++;
   endtask

   task automatic test_write_full();
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'hEE;
         #1;
         check_cnt++; if (mem_we !== 1'b0) $display("FAIL full_mem_we[%0d] got %b want 0", i, mem_we); else pass_cnt++;
         @(negedge wr_clk);
         check_cnt++; if (wr_ptr !== 8'h80) $display("FAIL full_wr_ptr[%0d] got %h want 80", i, wr_ptr); else pass_cnt++;
         check_cnt++; if (wr_ack !== 1'b0) $display("FAIL full_ack[%0d] got %b want 0", i, wr_ack); else pass_cnt++;
`ifdef WR_OVERFLOW_FLAG_EN
         check_cnt++; if (overflow !== 1'b1) $display("FAIL full_overflow[%0d] got %b want 1", i, overflow); else pass_cnt++;
`endif
      end
      wr_en = 1'b0;
      @(negedge wr_clk);
      @(negedge wr_clk);
      check_cnt++; if (fill_level !== 8'd90) $display("FAIL full_fill_hold got %0d want 90", fill_level); else pass_cnt++;
`ifdef WR_OVERFLOW_FLAG_EN
      check_cnt++; if (overflow !== 1'b1) $display("FAIL overflow_sticky got %b want 1", overflow); else pass_cnt++;
`endif
   endtask

   task automatic test_wrap();
      apply_reset();
      do_writes(89);
      check_cnt++; if (wr_ptr !== 8'h59) $display("FAIL wrap_start got %h want 59", wr_ptr); else pass_cnt++;
      rd_ptr = 8'h05;
      wr_en  = 1'b1;
      #1;
      check_cnt++; if (mem_addr !== 7'd89) $display("FAIL wrap_addr got %0d want 89", mem_addr); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd84) $display("FAIL wrap_fill_pre got %0d want 84", fill_level); else pass_cnt++;
      @(negedge wr_clk);
      wr_en = 1'b0;
      check_cnt++; if (wr_ptr !== 8'h80) $display("FAIL wrap_wr_ptr got %h want 80", wr_ptr); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd85) $display("FAIL wrap_fill got %0d want 85", fill_level); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b0) $display("FAIL wrap_full got %b want 0", fifo_full); else pass_cnt++;
      check_cnt++; if (almost_full !== 1'b1) $display("FAIL wrap_af got %b want 1", almost_full); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] wp;
      logic       lap_seen;
      apply_reset();
      do_writes(40);
      check_cnt++; if (fill_level !== 8'd40) $display("FAIL b2b_fill_start got %0d want 40", fill_level); else pass_cnt++;
      wp       = 8'd40;
      lap_seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         #1;
         check_cnt++; if (mem_we !== 1'b1) $display("FAIL b2b_mem_we[%0d] got %b want 1", i, mem_we); else pass_cnt++;
         @(posedge wr_clk);
         #1 rd_ptr = nxt(rd_ptr);
         @(negedge wr_clk);
         wp = nxt(wp);
         check_cnt++; if (wr_ptr !== wp) $display("FAIL b2b_wr_ptr[%0d] got %h want %h", i, wr_ptr, wp); else pass_cnt++;
         check_cnt++; if (fill_level !== 8'd40) $display("FAIL b2b_fill[%0d] got %0d want 40", i, fill_level); else pass_cnt++;
         if (wr_ptr[7]) lap_seen = 1'b1;
      end
      wr_en = 1'b0;
      check_cnt++; if (wr_ptr !== 8'h3C) $display("FAIL b2b_final_wr_ptr got %h want 3c", wr_ptr); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b1) $display("FAIL b2b_ack got %b want 1", wr_ack); else pass_cnt++;
      check_cnt++; if (lap_seen !== 1'b1) $display("FAIL b2b_lap_toggle got %b want 1", lap_seen); else pass_cnt++;
   endtask

   task automatic test_full_race();
      apply_reset();
      do_writes(90);
      check_cnt++; if (fifo_full !== 1'b1) $display("FAIL race_full_start got %b want 1", fifo_full); else pass_cnt++;
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      @(posedge wr_clk);
      #1 rd_ptr = 8'h01;
      @(negedge wr_clk);
      check_cnt++; if (wr_ptr !== 8'h80) $display("FAIL race_wr_ptr got %h want 80", wr_ptr); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b0) $display("FAIL race_ack got %b want 0", wr_ack); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd89) $display("FAIL race_fill got %0d want 89", fill_level); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b0) $display("FAIL race_full got %b want 0", fifo_full); else pass_cnt++;
`ifdef WR_OVERFLOW_FLAG_EN
      check_cnt++; if (overflow !== 1'b1) $display("FAIL race_overflow got %b want 1", overflow); else pass_cnt++;
`endif
      #1;
      check_cnt++; if (mem_we !== 1'b1) $display("FAIL race_retry_we got %b want 1", mem_we); else pass_cnt++;
      check_cnt++; if (mem_addr !== 7'd0) $display("FAIL race_retry_addr got %0d want 0", mem_addr); else pass_cnt++;
      @(negedge wr_clk);
      wr_en = 1'b0;
      check_cnt++; if (wr_ptr !== 8'h81) $display("FAIL race_retry_ptr got %h want 81", wr_ptr); else pass_cnt++;
      check_cnt++; if (wr_ack !== 1'b1) $display("FAIL race_retry_ack got %b want 1", wr_ack); else pass_cnt++;
      check_cnt++; if (fill_level !== 8'd90) $display("FAIL race_retry_fill got %0d want 90", fill_level); else pass_cnt++;
      check_cnt++; if (fifo_full !== 1'b1) $display("FAIL race_retry_full got %b want 1", fifo_full); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write_full();
      test_wrap();
      test_back_to_back();
      test_full_race();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/write_unit.md
# write_unit

Write-side pointer and status stage of the FIFO. It sits directly upstream of the read stage: it accepts writes, drives the storage write port, and produces `wr_ptr`, which the read stage compares against `rd_ptr` to derive `fifo_empty`. It uses the same wrap-bit pointer encoding as the read stage: the MSB is the lap bit and the lower `S-1` bits are the slot index. It also reports `fifo_full`, an almost-full warning, the fill level and a write acknowledge.

## Interface
- `S`, 8: pointer width; MSB is the lap bit, `[S-2:0]` is the slot index.
- `W`, 8: data width.
- `Depth`, 90: number of FIFO slots. Legal range is 2 to 2^(S-1). The read stage must use the same value.
- `AF_THRESH`, 80: `almost_full` asserts when `fill_level >= AF_THRESH`. Legal range is 1 to `Depth`.

- `wr_clk`  input  1  FIFO clock, shared with the read stage.
- `wr_rst`  input  1  asynchronous, active-high reset.
- `wr_en`  input  1  write request.
- `wr_data`  input  W  data to write.
- `rd_ptr`  input  S  read pointer from the read stage.
- `wr_ptr`  output  S  write pointer.
- `mem_we`  output  1  storage write enable.
- `mem_addr`  output  S-1  storage write address.
- `mem_wdata`  output  W  storage write data.
- `fifo_full`  output  1  FIFO full.
- `almost_full`  output  1  fill level at or above the threshold.
- `fill_level`  output  S  number of occupied slots, 0 to `Depth`.
- `wr_ack`  output  1  one-cycle pulse confirming an accepted write.
- `overflow`  output  1  sticky flag for a rejected write; present only with `WR_OVERFLOW_FLAG_EN`.

## Operation
- Accepted write: `acc = wr_en && !fifo_full`.
- Storage port (combinational):
  - `mem_we = acc`
  - `mem_addr = wr_ptr[S-2:0]`
  - `mem_wdata = wr_data`
  - Storage captures the data on the same `wr_clk` edge on which `wr_ptr` advances.
- Pointer update on `posedge wr_clk` when `acc`:
  - If `wr_ptr[S-2:0] < Depth-1`: the index increments and the lap bit holds.
  - If `wr_ptr[S-2:0] == Depth-1`: the index becomes 0 and the lap bit toggles.
  - Otherwise the pointer holds.
- `fifo_full` (combinational) is 1 when the lap bits differ and the indices are equal.
- `fill_level` (combinational):
  - Equal lap bits: `wr_idx - rd_idx`.
  - Different lap bits: `Depth - rd_idx + wr_idx`.
  - The arithmetic is S-bit wide with no overflow for legal `Depth`.
  - It equals `Depth` exactly when `fifo_full` is 1 and 0 exactly when the read stage sees empty.
- `almost_full = (fill_level >= AF_THRESH)`, combinational.
- `wr_ack` is a register: 1 in the cycle after an accepted write, 0 otherwise. Back-to-back accepted writes hold it at 1.
- Write while full: the write is dropped. The pointer holds, `mem_we` stays 0 and no `wr_ack` is produced.
- Write and read in the same cycle:
  - Both pointers advance on the same edge.
  - The write is accepted only if `fifo_full` was 0 before that edge. A read does not free a slot within the same cycle.
- Index values at or above `Depth` cannot be reached from reset. Their behaviour is undefined.

## Timing
- Reset (asynchronous, taking effect immediately):
  - `wr_ptr=0`, `wr_ack=0`, `overflow=0`.
  - Derived outputs with `rd_ptr=0`: `fifo_full=0`, `fill_level=0`, `almost_full=0`, `mem_we=0`.
- Reset mid-operation: all registers clear at once. The read stage must be reset together with this stage, otherwise `fill_level` is meaningless.
- Write latency:
  - `mem_we` is asserted in the same cycle as the request.
  - `wr_ptr`, `fill_level` and `fifo_full` reflect the write after 1 clock edge.
  - `wr_ack` follows 1 cycle after the accepting edge.
- `fifo_full`, `almost_full` and `fill_level` respond combinationally to `rd_ptr` changes.

## Configuration
- `WR_OVERFLOW_FLAG_EN` defined:
  - The `overflow` port exists.
  - It is set at any `wr_clk` edge where `wr_en && fifo_full`.
  - It stays set until `wr_rst`.
- `WR_OVERFLOW_FLAG_EN` not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: assert `wr_rst` asynchronously mid-cycle -> `wr_ptr=0`, `fifo_full=0`, `fill_level=0`, `wr_ack=0`, `overflow=0`.
- Fill: 90 consecutive writes with `rd_ptr` held at 0 -> `mem_addr` steps 0..89; `wr_ptr=8'h80`; `fifo_full=1`; `fill_level=90`; `almost_full` first rises after the 80th write.
- Write while full: hold `wr_en=1` for 3 cycles -> `mem_we=0`, `wr_ptr` stays `8'h80`, `wr_ack=0`, `overflow=1` and sticky (macro on).
- Wrap: starting from `wr_ptr=8'h59` (index 89), one write -> `wr_ptr=8'h80`; with `rd_ptr=8'h05`, `fill_level=85`.
- Simultaneous write and read: at `fill_level=40`, write plus read each cycle for 200 cycles -> `fill_level` stays 40, both lap bits toggle, no drops.
- Full-cycle race: with `fifo_full=1`, request a write while the read stage advances on the same edge -> write rejected, `fill_level` becomes 89, and a write in the next cycle is accepted.
